// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter_pkg
// Brief    : Shared encodings and default sizing for the memory bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_bus_arbiter_pkg;

  localparam int c_RISCV_ADDR_WIDTH       = 32;
  localparam int c_DEFAULT_TIMEOUT_CYCLES = 255;
  localparam int c_DEFAULT_STARVE_LIMIT   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/bus_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : bus_timeout_counter
// Brief    : Cycle counter that flags expiry after LIMIT enabled cycles.
// Revision : 1.0 - initial release
// ============================================================================
module bus_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int c_CW = $clog2(LIMIT);

  logic [c_CW-1:0] r_count;

  // expired is raised during the LIMIT-th enabled cycle after a clear
  assign expired = (r_count == c_CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : Fetch/LSU arbiter for one memory bus, single outstanding access.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = c_RISCV_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT_CYCLES,
  parameter int STARVE_LIMIT   = c_DEFAULT_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_err_i
);

  localparam int                    c_STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

  state_t                r_state, w_state_nxt;
  owner_t                r_owner, w_owner_nxt, w_sel;
  logic [c_STARVE_W-1:0] r_starve, w_starve_nxt;
  logic                  w_issue, w_rsp, w_starved;
  logic                  w_tmo_clear, w_tmo_enable, w_tmo_expired, w_timeout;

  assign w_tmo_clear  = (r_state == IDLE);
  assign w_tmo_enable = (r_state != IDLE);
  assign w_timeout    = w_tmo_enable && w_tmo_expired;
  assign w_starved    = instr_req_i && (r_starve == c_STARVE_MAX);

  bus_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_tmo_clear),
    .enable  (w_tmo_enable),
    .expired (w_tmo_expired)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_starve_nxt   = r_starve;
    w_sel          = r_owner;
    w_issue        = 1'b0;
    w_rsp          = 1'b0;
    instr_gnt_o    = 1'b0;
    data_gnt_o     = 1'b0;
    instr_rvalid_o = 1'b0;
    data_rvalid_o  = 1'b0;
    rdata_o        = '0;
    err_o          = 1'b0;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_be_o       = '0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;

    unique case (r_state)
      IDLE: begin
        if (data_req_i || instr_req_i) begin
          w_sel       = (data_req_i && !w_starved) ? OWNER_DATA : OWNER_INSTR;
          w_issue     = 1'b1;
          w_owner_nxt = w_sel;
          if (data_req_i && instr_req_i && (w_sel == OWNER_DATA) &&
              (r_starve != c_STARVE_MAX)) begin
            w_starve_nxt = r_starve + 1'b1;
          end
          w_state_nxt = mem_gnt_i ? RESP : ADDR;
        end
      end
      ADDR: begin
        // expiry beats a same-cycle gnt so a timed-out request is never accepted
        if (w_timeout) begin
          w_rsp       = 1'b1;
          err_o       = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_issue = 1'b1;
          if (mem_gnt_i) begin
            w_state_nxt = RESP;
          end
        end
      end
      RESP: begin
        if (mem_rvalid_i) begin
          w_rsp       = 1'b1;
          rdata_o     = mem_rdata_i;
          err_o       = mem_err_i;
          w_state_nxt = IDLE;
        end else if (w_timeout) begin
          w_rsp       = 1'b1;
          err_o       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    instr_gnt_o    = w_issue && mem_gnt_i && (w_sel == OWNER_INSTR);
    data_gnt_o     = w_issue && mem_gnt_i && (w_sel == OWNER_DATA);
    instr_rvalid_o = w_rsp && (r_owner == OWNER_INSTR);
    data_rvalid_o  = w_rsp && (r_owner == OWNER_DATA);

    if (instr_gnt_o) begin
      w_starve_nxt = '0;
    end

    if (w_issue) begin
      mem_req_o = 1'b1;
      if (w_sel == OWNER_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = 4'b1111;
        mem_addr_o  = instr_addr_i;
      end
    end

    // request inputs reach the outputs combinationally, so mask them in reset
    if (!rst_n) begin
      instr_gnt_o    = 1'b0;
      data_gnt_o     = 1'b0;
      instr_rvalid_o = 1'b0;
      data_rvalid_o  = 1'b0;
      rdata_o        = '0;
      err_o          = 1'b0;
      mem_req_o      = 1'b0;
      mem_we_o       = 1'b0;
      mem_be_o       = '0;
      mem_addr_o     = '0;
      mem_wdata_o    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_owner  <= OWNER_DATA;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_starve <= w_starve_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Brief    : Directed self-checking bench with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  localparam int AW  = 32;
  localparam int TMO = 8;
  localparam int SL  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_req_i = 1'b0;
  logic [AW-1:0] instr_addr_i = '0;
  logic          instr_gnt_o, instr_rvalid_o;
  logic          data_req_i = 1'b0;
  logic          data_we_i = 1'b0;
  logic [3:0]    data_be_i = '0;
  logic [AW-1:0] data_addr_i = '0;
  logic [31:0]   data_wdata_i = '0;
  logic          data_gnt_o, data_rvalid_o;
  logic [31:0]   rdata_o;
  logic          err_o;
  logic          mem_req_o, mem_we_o;
  logic [3:0]    mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic          mem_gnt_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [31:0]   mem_rdata_i = '0;
  logic          mem_err_i = 1'b0;

  bit hold_data = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TMO),
    .STARVE_LIMIT   (SL)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .rdata_o        (rdata_o),
    .err_o          (err_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .mem_err_i      (mem_err_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_busy: a transaction is open; m_acc: its address phase was accepted;
  // m_age: cycles the open transaction has been outstanding.
  bit m_busy = 1'b0, m_acc = 1'b0, m_who = 1'b1;
  int m_age = 0, m_starve = 0;
  bit n_busy = 1'b0, n_acc = 1'b0, n_who = 1'b1;
  int n_age = 0, n_starve = 0;

  task automatic req_fields(input bit who, output logic we, output logic [3:0] be,
                            output logic [31:0] addr, output logic [31:0] wd);
    if (who) begin
      we = data_we_i; be = data_be_i; addr = data_addr_i; wd = data_wdata_i;
    end else begin
      we = 1'b0; be = 4'hF; addr = instr_addr_i; wd = 32'h0;
    end
  endtask

  always @(negedge clk) begin : model_cmp
    logic e_ig, e_dg, e_ir, e_dr, e_req, e_we, e_err;
    logic [3:0] e_be;
    logic [31:0] e_addr, e_wd, e_rd;
    bit who;
    e_ig = 0; e_dg = 0; e_ir = 0; e_dr = 0; e_req = 0; e_we = 0; e_err = 0;
    e_be = 0; e_addr = 0; e_wd = 0; e_rd = 0;
    n_busy = m_busy; n_acc = m_acc; n_who = m_who; n_age = m_age; n_starve = m_starve;
    if (!rst_n) begin
      n_busy = 0; n_acc = 0; n_who = 1; n_age = 0; n_starve = 0;
    end else if (!m_busy) begin
      if (instr_req_i || data_req_i) begin
        who = (data_req_i && !(instr_req_i && m_starve >= SL)) ? 1'b1 : 1'b0;
        e_req = 1;
        req_fields(who, e_we, e_be, e_addr, e_wd);
        if (data_req_i && instr_req_i && who)
          n_starve = (m_starve + 1 > SL) ? SL : m_starve + 1;
        if (mem_gnt_i) begin
          if (who) e_dg = 1;
          else begin e_ig = 1; n_starve = 0; end
        end
        n_busy = 1; n_acc = mem_gnt_i; n_who = who; n_age = 0;
      end
    end else begin
      if (!m_acc) begin
        if (m_age == TMO - 1) begin
          e_err = 1; e_ir = !m_who; e_dr = m_who; n_busy = 0;
        end else begin
          e_req = 1;
          req_fields(m_who, e_we, e_be, e_addr, e_wd);
          if (mem_gnt_i) begin
            e_ig = !m_who; e_dg = m_who; n_acc = 1;
            if (!m_who) n_starve = 0;
          end
        end
      end else if (mem_rvalid_i) begin
        e_ir = !m_who; e_dr = m_who; e_rd = mem_rdata_i; e_err = mem_err_i; n_busy = 0;
      end else if (m_age == TMO - 1) begin
        e_ir = !m_who; e_dr = m_who; e_err = 1; n_busy = 0;
      end
      n_age = m_age + 1;
    end
    chk("m_instr_gnt", instr_gnt_o, e_ig);
    chk("m_data_gnt", data_gnt_o, e_dg);
    chk("m_instr_rvalid", instr_rvalid_o, e_ir);
    chk("m_data_rvalid", data_rvalid_o, e_dr);
    chk("m_rdata", rdata_o, e_rd);
    chk("m_err", err_o, e_err);
    chk("m_mem_req", mem_req_o, e_req);
    if (e_req) begin
      chk("m_mem_we", mem_we_o, e_we);
      chk("m_mem_be", mem_be_o, e_be);
      chk("m_mem_addr", mem_addr_o, e_addr);
      chk("m_mem_wdata", mem_wdata_o, e_wd);
    end
  end

  always @(posedge clk) begin
    m_busy <= n_busy; m_acc <= n_acc; m_who <= n_who; m_age <= n_age; m_starve <= n_starve;
  end

  // ---------------- stimulus helpers ----------------
  // call right after a falling edge; requesters drop once their gnt was seen
  task automatic finish_cyc();
    bit gi, gd;
    gi = instr_gnt_o;
    gd = data_gnt_o;
    @(posedge clk);
    #1;
    if (gi) instr_req_i = 1'b0;
    if (gd && !hold_data) data_req_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    mem_rdata_i  = '0;
  endtask

  task automatic cyc();
    @(negedge clk);
    finish_cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // reset with a live request: outputs must stay quiet
    instr_req_i = 1'b1; instr_addr_i = 32'h80; mem_gnt_i = 1'b1;
    @(negedge clk);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_instr_gnt", instr_gnt_o, 0);
    chk("rst_rdata", rdata_o, 0);
    @(posedge clk); #1;
    instr_req_i = 1'b0;
    rst_n = 1'b1;

    // fetch only, zero-wait grant, one-cycle response
    instr_req_i = 1'b1; instr_addr_i = 32'h100;
    @(negedge clk);
    chk("t1_instr_gnt", instr_gnt_o, 1);
    chk("t1_mem_addr", mem_addr_o, 32'h100);
    chk("t1_mem_be", mem_be_o, 4'hF);
    finish_cyc();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_instr_rvalid", instr_rvalid_o, 1);
    chk("t1_rdata", rdata_o, 32'hDEADBEEF);
    chk("t1_err", err_o, 0);
    finish_cyc();

    // simultaneous fetch and store: data first
    instr_req_i = 1'b1; instr_addr_i = 32'h104;
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0011;
    data_addr_i = 32'h2000; data_wdata_i = 32'h1234;
    @(negedge clk);
    chk("t2_data_gnt", data_gnt_o, 1);
    chk("t2_instr_gnt", instr_gnt_o, 0);
    chk("t2_mem_we", mem_we_o, 1);
    chk("t2_mem_be", mem_be_o, 4'b0011);
    chk("t2_mem_wdata", mem_wdata_o, 32'h1234);
    finish_cyc();
    mem_rvalid_i = 1'b1;
    @(negedge clk);
    chk("t2_data_rvalid", data_rvalid_o, 1);
    finish_cyc();
    @(negedge clk);
    chk("t2_fetch_next", instr_gnt_o, 1);
    chk("t2_fetch_we", mem_we_o, 0);
    finish_cyc();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE0001;
    cyc();

    // starvation guard: four data wins then fetch is forced through
    hold_data = 1'b1;
    data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h3000;
    instr_req_i = 1'b1; instr_addr_i = 32'h200;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 4) chk("t3_fetch_forced", instr_gnt_o, 1);
      else        chk("t3_data_wins", data_gnt_o, 1);
      finish_cyc();
      mem_rvalid_i = 1'b1; mem_rdata_i = k;
      cyc();
      if (k == 4) begin
        instr_req_i = 1'b1; instr_addr_i = 32'h204;
      end
    end
    hold_data = 1'b0; data_req_i = 1'b0;
    @(negedge clk);
    chk("t3_fetch_after", instr_gnt_o, 1);
    finish_cyc();
    mem_rvalid_i = 1'b1;
    cyc();

    // grant withheld three cycles; owner sticks despite a data request
    mem_gnt_i = 1'b0;
    instr_req_i = 1'b1; instr_addr_i = 32'h300;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_gnt_i = 1'b1;
      if (k == 1) begin
        data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h4000; data_wdata_i = 32'h55;
      end
      @(negedge clk);
      chk("t4_mem_req", mem_req_o, 1);
      chk("t4_mem_addr", mem_addr_o, 32'h300);
      chk("t4_data_gnt", data_gnt_o, 0);
      chk("t4_instr_gnt", instr_gnt_o, (k == 3));
      finish_cyc();
    end
    mem_rvalid_i = 1'b1;
    cyc();
    @(negedge clk);
    chk("t4_data_then", data_gnt_o, 1);
    finish_cyc();
    mem_rvalid_i = 1'b1;
    cyc();

    // response never arrives: timeout error 8 cycles after issue
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h40;
    @(negedge clk);
    chk("t5_data_gnt", data_gnt_o, 1);
    finish_cyc();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("t5_data_rvalid", data_rvalid_o, (k == 8));
      if (k == 8) begin
        chk("t5_err", err_o, 1);
        chk("t5_rdata", rdata_o, 0);
      end
      finish_cyc();
    end
    instr_req_i = 1'b1; instr_addr_i = 32'h500;
    @(negedge clk);
    chk("t5_next_gnt", instr_gnt_o, 1);
    finish_cyc();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77;
    @(negedge clk);
    chk("t5_next_rvalid", instr_rvalid_o, 1);
    chk("t5_next_err", err_o, 0);
    finish_cyc();

    // address phase that never gets accepted: late gnt must be ignored
    mem_gnt_i = 1'b0;
    data_req_i = 1'b1; data_addr_i = 32'h44;
    cyc();
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) mem_gnt_i = 1'b1;
      @(negedge clk);
      chk("t5b_mem_req", mem_req_o, (k != 8));
      if (k == 8) begin
        chk("t5b_no_gnt", data_gnt_o, 0);
        chk("t5b_rvalid", data_rvalid_o, 1);
        chk("t5b_err", err_o, 1);
      end
      finish_cyc();
    end
    data_req_i = 1'b0;

    // reset while waiting for a response, then a late rvalid
    instr_req_i = 1'b1; instr_addr_i = 32'h600;
    @(negedge clk);
    chk("t6_gnt", instr_gnt_o, 1);
    finish_cyc();
    rst_n = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD;
    @(negedge clk);
    chk("t6_rst_rvalid", instr_rvalid_o, 0);
    chk("t6_rst_rdata", rdata_o, 0);
    finish_cyc();
    rst_n = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD;
    @(negedge clk);
    chk("t6_late_rvalid", instr_rvalid_o, 0);
    chk("t6_late_rdata", rdata_o, 0);
    finish_cyc();
    instr_req_i = 1'b1; instr_addr_i = 32'h700;
    @(negedge clk);
    chk("t6_new_gnt", instr_gnt_o, 1);
    chk("t6_new_addr", mem_addr_o, 32'h700);
    finish_cyc();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11;
    @(negedge clk);
    chk("t6_new_rvalid", instr_rvalid_o, 1);
    chk("t6_new_rdata", rdata_o, 32'h11);
    finish_cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
